// File: rtl/bmp_to_video_stream_if.sv
// Raster video bundle of the BMP replay source: frame request in, sync/pixel/geometry out.
interface bmp_to_video_stream_if;
  logic            vout_begin;
  logic            vout_vsync;
  logic            vout_hsync;
  logic [2:0][7:0] vout_dat;
  logic            vout_valid;
  logic            vout_done;
  logic [15:0]     vout_xres;
  logic [15:0]     vout_yres;

  modport master (
    input  vout_begin,
    output vout_vsync, vout_hsync, vout_dat, vout_valid, vout_done, vout_xres, vout_yres
  );

  modport slave (
    output vout_begin,
    input  vout_vsync, vout_hsync, vout_dat, vout_valid, vout_done, vout_xres, vout_yres
  );
endinterface

// File: rtl/bmp_to_video_stream.sv
// Replays a 24bpp BMP image, supplied as a byte-image parameter, as one raster frame per request.
module bmp_to_video_stream #(
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BACK   = 220,
  parameter int unsigned H_DISP   = 1280,
  parameter int unsigned H_FRONT  = 110,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 20,
  parameter int unsigned V_DISP   = 720,
  parameter int unsigned V_FRONT  = 5,
  // File contents, byte 0 in the least significant byte; zero length means no file.
  parameter int unsigned BmpBytes = 0,
  parameter logic [8*((BmpBytes > 0) ? BmpBytes : 1)-1:0] BmpData = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  bmp_to_video_stream_if.master vout_io
);

  localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned MemBytes = (BmpBytes > 0) ? BmpBytes : 1;
  localparam int unsigned AW       = (MemBytes > 1) ? $clog2(MemBytes) : 1;

  function automatic logic [7:0] hdr_byte(input int unsigned idx);
    logic [8*MemBytes-1:0] sh;
    sh = BmpData >> (8 * idx);
    return (idx < BmpBytes) ? sh[7:0] : 8'h00;
  endfunction

  function automatic logic [31:0] hdr_word(input int unsigned idx);
    return {hdr_byte(idx + 3), hdr_byte(idx + 2), hdr_byte(idx + 1), hdr_byte(idx)};
  endfunction

  localparam logic [31:0] PixOff  = hdr_word(10);
  localparam logic [31:0] ImgW    = hdr_word(18);
  localparam logic [31:0] ImgHRaw = hdr_word(22);
  localparam logic [15:0] Bpp     = {hdr_byte(29), hdr_byte(28)};
  localparam logic [31:0] Comp    = hdr_word(30);
  localparam bit          HdrOk   = (BmpBytes >= 54) && (Bpp == 16'd24) && (Comp == 32'd0);
  localparam bit          TopDown = ImgHRaw[31];
  localparam logic [31:0] ImgHAbs = TopDown ? (~ImgHRaw + 32'd1) : ImgHRaw;
  localparam logic [31:0] Stride  = ((ImgW * 32'd3 + 32'd3) >> 2) << 2;
  localparam logic [31:0] XRes    = HdrOk ? ImgW : H_DISP;
  localparam logic [31:0] YRes    = HdrOk ? ImgHAbs : V_DISP;

  localparam logic [HW-1:0] HMax = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VMax = VW'(V_TOTAL - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        st_q, st_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          done_q, done_d;

  logic [7:0] mem [MemBytes];

  for (genvar i = 0; i < MemBytes; i++) begin : g_mem
    assign mem[i] = BmpData[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= StIdle;
      hcnt_q <= '0;
      vcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    done_d = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (vout_io.vout_begin) begin
          st_d   = StRun;
          hcnt_d = '0;
          vcnt_d = '0;
        end
      end
      StRun: begin
        if (hcnt_q == HMax) begin
          hcnt_d = '0;
          if (vcnt_q == VMax) begin
            vcnt_d = '0;
            done_d = 1'b1;
            // A request in the final cycle chains straight into the next frame.
            st_d   = vout_io.vout_begin ? StRun : StIdle;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  logic        run, hsync, vsync, valid;
  logic [31:0] px, py, row, addr;
  logic [AW-1:0] a0, a1, a2;
  logic [23:0] dat;

  always_comb begin
    run   = (st_q == StRun);
    hsync = run && (32'(hcnt_q) < H_SYNC);
    vsync = run && (32'(vcnt_q) < V_SYNC);
    valid = run
         && (32'(hcnt_q) >= H_SYNC + H_BACK) && (32'(hcnt_q) < H_SYNC + H_BACK + H_DISP)
         && (32'(vcnt_q) >= V_SYNC + V_BACK) && (32'(vcnt_q) < V_SYNC + V_BACK + V_DISP);
    px    = 32'(hcnt_q) - (H_SYNC + H_BACK);
    py    = 32'(vcnt_q) - (V_SYNC + V_BACK);
    // Bottom-up files store the last display line first.
    row   = TopDown ? py : (YRes - 32'd1 - py);
    addr  = PixOff + row * Stride + px * 32'd3;
    a0    = AW'(addr);
    a1    = AW'(addr + 32'd1);
    a2    = AW'(addr + 32'd2);
    dat   = '0;
    if (valid && HdrOk && (px < XRes) && (py < YRes) && (addr + 32'd2 < MemBytes)) begin
      dat = {mem[a2], mem[a1], mem[a0]};
    end
  end

  assign vout_io.vout_hsync = hsync;
  assign vout_io.vout_vsync = vsync;
  assign vout_io.vout_valid = valid;
  assign vout_io.vout_dat   = dat;
  assign vout_io.vout_done  = done_q;
  assign vout_io.vout_xres  = XRes[15:0];
  assign vout_io.vout_yres  = YRes[15:0];

endmodule

// File: tb/tb_bmp_to_video_stream.sv
// Self-checking bench: three small-raster sources (bottom-up 4x2, top-down padded 3x2, no file).
module tb_bmp_to_video_stream;

  localparam int HS = 2, HB = 3, HD = 4, HF = 2;
  localparam int VS = 1, VB = 2, VD = 2, VF = 1;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FRAME = HT * VT;

  function automatic logic [1023:0] put(input logic [1023:0] v, input int idx, input int nb,
                                        input int val);
    logic [1023:0] m;
    m = ((1024'(1) << (8 * nb)) - 1024'(1)) << (8 * idx);
    return (v & ~m) | ((1024'(val) << (8 * idx)) & m);
  endfunction

  // Builds a BMP file image; pixel bytes count up from base in top-down raster order.
  function automatic logic [1023:0] make_bmp(input int w, input int h, input int base);
    logic [1023:0] v;
    int hh, stride, y;
    v = '0;
    hh = (h < 0) ? -h : h;
    stride = ((w * 3 + 3) / 4) * 4;
    v = put(v, 0, 1, 8'h42);
    v = put(v, 1, 1, 8'h4D);
    v = put(v, 2, 4, 54 + stride * hh);
    v = put(v, 10, 4, 54);
    v = put(v, 14, 4, 40);
    v = put(v, 18, 4, w);
    v = put(v, 22, 4, h);
    v = put(v, 26, 2, 1);
    v = put(v, 28, 2, 24);
    for (int r = 0; r < hh; r++) begin
      y = (h > 0) ? (hh - 1 - r) : r;
      for (int b = 0; b < stride; b++) begin
        if (b < w * 3) v = put(v, 54 + r * stride + b, 1, (base + 3 * y * w + b) & 255);
        else           v = put(v, 54 + r * stride + b, 1, 8'hEE);
      end
    end
    return v;
  endfunction

  localparam logic [1023:0] BmpA = make_bmp(4, 2, 8'h01);
  localparam logic [1023:0] BmpB = make_bmp(3, -2, 8'h40);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic begin_r = 1'b0;
  always #5 clk = ~clk;

  bmp_to_video_stream_if if_a ();
  bmp_to_video_stream_if if_b ();
  bmp_to_video_stream_if if_c ();
  assign if_a.vout_begin = begin_r;
  assign if_b.vout_begin = begin_r;
  assign if_c.vout_begin = begin_r;

  bmp_to_video_stream #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .V_SYNC(VS),
    .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .BmpBytes(128), .BmpData(BmpA))
    dut_a (.clk(clk), .rst(rst), .vout_io(if_a));
  bmp_to_video_stream #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .V_SYNC(VS),
    .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .BmpBytes(128), .BmpData(BmpB))
    dut_b (.clk(clk), .rst(rst), .vout_io(if_b));
  bmp_to_video_stream #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .V_SYNC(VS),
    .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .BmpBytes(0), .BmpData(8'h00))
    dut_c (.clk(clk), .rst(rst), .vout_io(if_c));

  logic hs [3], vs [3], va [3], dn [3];
  logic [23:0] dt [3];
  logic [15:0] xr [3], yr [3];
  assign hs[0] = if_a.vout_hsync; assign hs[1] = if_b.vout_hsync; assign hs[2] = if_c.vout_hsync;
  assign vs[0] = if_a.vout_vsync; assign vs[1] = if_b.vout_vsync; assign vs[2] = if_c.vout_vsync;
  assign va[0] = if_a.vout_valid; assign va[1] = if_b.vout_valid; assign va[2] = if_c.vout_valid;
  assign dn[0] = if_a.vout_done;  assign dn[1] = if_b.vout_done;  assign dn[2] = if_c.vout_done;
  assign dt[0] = if_a.vout_dat;   assign dt[1] = if_b.vout_dat;   assign dt[2] = if_c.vout_dat;
  assign xr[0] = if_a.vout_xres;  assign xr[1] = if_b.vout_xres;  assign xr[2] = if_c.vout_xres;
  assign yr[0] = if_a.vout_yres;  assign yr[1] = if_b.vout_yres;  assign yr[2] = if_c.vout_yres;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    begin_r = 1'b1;
    step();
    begin_r = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (dn[0] !== 1'b1 && n < 200) begin step(); n++; end
    check(name, 32'(n < 200), 32'd1);
    step();
  endtask

  // Expected image content, addressed in display coordinates.
  function automatic logic [23:0] exp_pix(input int k, input int x, input int y);
    int w, h, base, b;
    if (k == 0)      begin w = 4; h = 2; base = 8'h01; end
    else if (k == 1) begin w = 3; h = 2; base = 8'h40; end
    else return 24'h0;
    if (x >= w || y >= h) return 24'h0;
    b = base + 3 * (y * w + x);
    return {8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  typedef struct {int x; int y; logic [23:0] a; logic [23:0] b;} pix_vec_t;
  typedef struct {logic [15:0] xres; logic [15:0] yres;} res_vec_t;
  pix_vec_t tv [8];
  res_vec_t rv [3];

  initial begin
    int n, nvalid, hrise, vhigh, first_valid, done_at, ndone;
    logic prev_hs;
    bit mrun, mdone;
    int t, bprob, h, v, x, y;
    logic ehs, evs, eva;
    logic [23:0] edt;

    tv[0] = '{0, 0, 24'h030201, 24'h424140};
    tv[1] = '{1, 0, 24'h060504, 24'h454443};
    tv[2] = '{2, 0, 24'h090807, 24'h484746};
    tv[3] = '{3, 0, 24'h0c0b0a, 24'h000000};
    tv[4] = '{0, 1, 24'h0f0e0d, 24'h4b4a49};
    tv[5] = '{1, 1, 24'h121110, 24'h4e4d4c};
    tv[6] = '{2, 1, 24'h151413, 24'h51504f};
    tv[7] = '{3, 1, 24'h181716, 24'h000000};
    rv[0] = '{16'd4, 16'd2};
    rv[1] = '{16'd3, 16'd2};
    rv[2] = '{16'd4, 16'd2};

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("idle_out_%0d", k), {28'(0), hs[k], vs[k], va[k], dn[k]}, 32'd0);
      check($sformatf("idle_dat_%0d", k), 32'(dt[k]), 32'd0);
      check($sformatf("xres_%0d", k), 32'(xr[k]), 32'(rv[k].xres));
      check($sformatf("yres_%0d", k), 32'(yr[k]), 32'(rv[k].yres));
    end

    // Pixel order, padding and missing-file content.
    start_frame();
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (va[0] !== 1'b1 && n < 100) begin step(); n++; end
      check("pix_wait", 32'(n < 100), 32'd1);
      check($sformatf("pixA_%0d_%0d", tv[i].x, tv[i].y), 32'(dt[0]), 32'(tv[i].a));
      check($sformatf("pixB_%0d_%0d", tv[i].x, tv[i].y), 32'(dt[1]), 32'(tv[i].b));
      check($sformatf("pixC_%0d_%0d", tv[i].x, tv[i].y), {29'(0), va[1], va[2], dt[2] == 24'h0},
            32'd7);
      step();
    end
    wait_done("frame1_done_wait");

    // Frame timing.
    start_frame();
    nvalid = 0; hrise = 0; vhigh = 0; first_valid = -1; done_at = -1; ndone = 0; prev_hs = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (va[0]) begin nvalid++; if (first_valid < 0) first_valid = i; end
      if (hs[0] && !prev_hs) hrise++;
      prev_hs = hs[0];
      if (vs[0]) vhigh++;
      if (dn[0]) begin ndone++; done_at = i; end
      step();
    end
    check("valid_count", 32'(nvalid), 32'(HD * VD));
    check("hsync_rises", 32'(hrise), 32'(VT));
    check("vsync_high", 32'(vhigh), 32'(VS * HT));
    check("first_valid", 32'(first_valid), 32'((VS + VB) * HT + HS + HB));
    check("done_at", 32'(done_at), 32'(FRAME));
    check("done_width", 32'(ndone), 32'd1);

    // Begin pulsed mid-frame is ignored.
    start_frame();
    ndone = 0; done_at = -1;
    for (int i = 0; i < 150; i++) begin
      begin_r = (i == 20);
      if (dn[0]) begin ndone++; done_at = i; end
      step();
    end
    begin_r = 1'b0;
    check("midbegin_ndone", 32'(ndone), 32'd1);
    check("midbegin_done_at", 32'(done_at), 32'(FRAME));

    // Begin held through the last cycle chains frames.
    begin_r = 1'b1;
    step();
    ndone = 0;
    for (int i = 0; i < 140; i++) begin
      if (dn[0]) ndone++;
      if (i == FRAME) check("chain_restart", {30'(0), hs[0], dn[0]}, 32'd3);
      step();
    end
    begin_r = 1'b0;
    check("chain_ndone", 32'(ndone), 32'd2);
    wait_done("chain_drain");

    // Reset mid-frame aborts without done.
    start_frame();
    repeat (30) step();
    rst = 1'b1;
    #1;
    check("rst_mid_out", {27'(0), hs[0], vs[0], va[0], dn[0], dt[0] != 24'h0}, 32'd0);
    step();
    rst = 1'b0;
    ndone = 0; nvalid = 0;
    for (int i = 0; i < 100; i++) begin
      if (dn[0]) ndone++;
      if (va[0] || hs[0]) nvalid++;
      step();
    end
    check("rst_mid_nodone", 32'(ndone), 32'd0);
    check("rst_mid_idle", 32'(nvalid), 32'd0);

    // Randomized requests and resets against a frame-index model.
    mrun = 1'b0; mdone = 1'b0; t = 0; bprob = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) bprob = (bprob == 3) ? 90 : 3;
      begin_r = ($urandom_range(0, 99) < bprob);
      rst = ($urandom_range(0, 399) == 0);
      if (rst) begin mrun = 1'b0; mdone = 1'b0; t = 0; end
      @(negedge clk);
      h = t % HT;
      v = t / HT;
      ehs = mrun && h < HS;
      evs = mrun && v < VS;
      eva = mrun && h >= HS + HB && h < HS + HB + HD && v >= VS + VB && v < VS + VB + VD;
      x = h - HS - HB;
      y = v - VS - VB;
      for (int k = 0; k < 3; k++) begin
        edt = eva ? exp_pix(k, x, y) : 24'h0;
        check($sformatf("rand_%0d_c%0d", k, c), {hs[k], vs[k], va[k], dn[k], dt[k]},
              {ehs, evs, eva, mdone, edt});
      end
      @(posedge clk);
      if (!rst) begin
        mdone = mrun && (t == FRAME - 1);
        if (mrun) begin
          if (t == FRAME - 1) begin mrun = begin_r; t = 0; end
          else t++;
        end else if (begin_r) begin
          mrun = 1'b1;
          t = 0;
        end
      end
      #1;
    end
    rst = 1'b0;
    begin_r = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
